core_sequencer: RTL

Multi-cycle sequencer for the 8-opcode core. Steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB, and owns the program counter. Qualifies the combinational decoder's RegWrite/MemWrite with single-cycle enables. Provides a Start/Done handshake to the top level, a data-memory wait handshake with timeout, and a retired-instruction counter.

---
 rtl/core_pkg.sv | 23 ++
 rtl/core_sequencer_sat_counter.sv | 26 ++
 rtl/core_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared opcode encodings and sequencer state type for the 8-opcode core.
package core_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_LSH   = 3'b100;
  localparam logic [2:0] OP_RSH   = 3'b101;
  localparam logic [2:0] OP_BNEZ  = 3'b110;
  localparam logic [2:0] OP_RLSH  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/core_sequencer_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: owns the PC, qualifies write
// strobes, handles the memory wait/timeout and counts retired instructions.
module core_sequencer
  import core_pkg::*;
#(
  parameter int PC_W        = 10,
  parameter int PROG_LEN    = 1024,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Halt_req,
  input  logic [2:0]       Opcode,
  input  logic             Branch_cond,
  input  logic [PC_W-1:0]  Target,
  input  logic             Mem_ready,
  output logic [PC_W-1:0]  PC,
  output logic             Ir_load,
  output logic             RegWrite_en,
  output logic             MemRead_en,
  output logic             MemWrite_en,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [CNT_W-1:0] Instr_count
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
  localparam logic [PC_W:0] END_PC_INC = (PC_W + 1)'(PROG_LEN);

  seq_state_t        r_state;
  seq_state_t        w_next;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_next;
  logic [PC_W:0]     w_pc_inc;
  logic [TMO_W-1:0]  w_tmo;
  logic              w_retire;
  logic              w_taken;
  logic              w_start_run;
  logic              w_timeout;
  logic              r_ir_load;
  logic              r_reg_we;
  logic              r_mem_re;
  logic              r_mem_we;
  logic              r_error;

  assign w_pc_inc = {1'b0, r_pc} + (PC_W + 1)'(1);

  always_comb begin
    w_next      = r_state;
    w_pc_next   = r_pc;
    w_retire    = 1'b0;
    w_taken     = 1'b0;
    w_start_run = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (Start) begin
          w_next      = S_FETCH;
          w_pc_next   = '0;
          w_start_run = 1'b1;
        end
      end
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if ((Opcode == OP_LOAD) || (Opcode == OP_STORE)) begin
          w_next = S_MEM;
        end else if (Opcode == OP_BNEZ) begin
          w_retire = 1'b1;
          w_taken  = Branch_cond;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        // Mem_ready on the final allowed cycle still wins over the timeout.
        if (Mem_ready) begin
          if (Opcode == OP_LOAD) w_next = S_WB;
          else                   w_retire = 1'b1;
        end else if (w_tmo == TMO_LAST) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      S_WB:    w_retire = 1'b1;
      default: w_next = S_IDLE;
    endcase

    // Ending on the last program slot keeps PC there; a halt always advances it.
    if (w_retire) begin
      if (Halt_req) begin
        w_next    = S_DONE;
        w_pc_next = w_taken ? Target : w_pc_inc[PC_W-1:0];
      end else if (w_taken) begin
        w_next    = S_FETCH;
        w_pc_next = Target;
      end else if (w_pc_inc == END_PC_INC) begin
        w_next = S_DONE;
      end else begin
        w_next    = S_FETCH;
        w_pc_next = w_pc_inc[PC_W-1:0];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir_load <= 1'b0;
      r_reg_we  <= 1'b0;
      r_mem_re  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_pc      <= w_pc_next;
      r_ir_load <= (w_next == S_FETCH);
      r_reg_we  <= (w_next == S_WB);
      r_mem_re  <= (w_next == S_MEM) && (Opcode == OP_LOAD);
      r_mem_we  <= (w_next == S_MEM) && (Opcode == OP_STORE);
      if (w_start_run)    r_error <= 1'b0;
      else if (w_timeout) r_error <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_instr_cnt (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_clear (w_start_run),
    .i_inc   (w_retire),
    .o_count (Instr_count)
  );

  sat_counter #(.WIDTH(TMO_W)) u_tmo_cnt (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_clear (r_state != S_MEM),
    .i_inc   ((r_state == S_MEM) && !Mem_ready),
    .o_count (w_tmo)
  );

  assign PC          = r_pc;
  assign Ir_load     = r_ir_load;
  assign RegWrite_en = r_reg_we;
  assign MemRead_en  = r_mem_re;
  assign MemWrite_en = r_mem_we;
  assign Busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign Done        = (r_state == S_DONE);
  assign Error       = r_error;

endmodule
